// File: rtl/lap_history_buffer.sv
// Lap history buffer: DEPTH-entry ring of captured BCD times browsed by a LIVE/BROWSE recall FSM.
// q0..q3 are registered (one cycle behind d or behind the lap_idx update); no backpressure, pulses act at once.
module lap_history_buffer #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       lap,
  input  logic       recall,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [3:0] lap_idx,
  output logic [4:0] count,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {LIVE, BROWSE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [4:0]    cnt, cnt_nxt;
  logic [4:0]    idx, idx_nxt;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   live_word;
  logic [15:0]   rd_word;
  logic [15:0]   q_word;
  logic [PW-1:0] rd_addr;

  assign live_word = {d3, d2, d1, d0};
  // idx == DEPTH folds to wr_ptr, i.e. the oldest slot once the ring is full
  assign rd_addr   = wr_ptr - idx[PW-1:0];
  assign rd_word   = mem[rd_addr];

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    if (clr) begin
      state_nxt  = LIVE;
      wr_ptr_nxt = '0;
      cnt_nxt    = '0;
      idx_nxt    = '0;
    end else if (lap) begin
      wr_ptr_nxt = wr_ptr + PW'(1);
      if (cnt != 5'(DEPTH)) cnt_nxt = cnt + 5'd1;
      state_nxt  = LIVE;
      idx_nxt    = '0;
    end else if (recall) begin
      case (state)
        LIVE: begin
          if (cnt != 5'd0) begin
            state_nxt = BROWSE;
            idx_nxt   = 5'd1;
          end
        end
        BROWSE: begin
          if (idx < cnt) begin
            idx_nxt = idx + 5'd1;
          end else begin
            state_nxt = LIVE;
            idx_nxt   = '0;
          end
        end
        default: state_nxt = LIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= LIVE;
      wr_ptr <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
    end
  end

  // Display follows the registered state, so a browse step shows up one cycle after lap_idx moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_word <= '0;
    end else if (clr) begin
      q_word <= '0;
    end else if (state == BROWSE) begin
      q_word <= rd_word;
    end else begin
      q_word <= live_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clr && lap) mem[wr_ptr] <= live_word;
  end

  assign {q3, q2, q1, q0} = q_word;
  assign lap_idx          = idx[3:0];
  assign count            = cnt;
  assign full             = (cnt == 5'(DEPTH));
  assign empty            = (cnt == 5'd0);

endmodule

// File: tb/tb_lap_history_buffer.sv
// Randomized bench for lap_history_buffer against a queue-based lap history model.
module tb_lap_history_buffer;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, clr, lap, recall;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] q0, q1, q2, q3;
  logic [3:0] lap_idx;
  logic [4:0] count;
  logic       full, empty;

  int checks = 0;
  int errors = 0;

  // Model: stored laps oldest-first, browse position counted back from the newest
  logic [15:0] hist[$];
  int          m_idx;
  bit          m_browse;
  logic [15:0] m_q;

  always #5 clk = ~clk;

  lap_history_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .lap(lap), .recall(recall),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .lap_idx(lap_idx), .count(count), .full(full), .empty(empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_idx    = 0;
    m_browse = 0;
    m_q      = '0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    w = {d3, d2, d1, d0};
    if (clr) begin
      model_reset();
    end else begin
      m_q = m_browse ? hist[hist.size() - m_idx] : w;
      if (lap) begin
        hist.push_back(w);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        m_browse = 0;
        m_idx    = 0;
      end else if (recall) begin
        if (!m_browse) begin
          if (hist.size() > 0) begin
            m_browse = 1;
            m_idx    = 1;
          end
        end else if (m_idx < hist.size()) begin
          m_idx++;
        end else begin
          m_browse = 0;
          m_idx    = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " q"}, {16'h0, q3, q2, q1, q0}, {16'h0, m_q});
    check_eq({tag, " lap_idx"}, {28'h0, lap_idx}, m_idx);
    check_eq({tag, " count"}, {27'h0, count}, hist.size());
    check_eq({tag, " full"}, {31'h0, full}, (hist.size() == DEPTH) ? 1 : 0);
    check_eq({tag, " empty"}, {31'h0, empty}, (hist.size() == 0) ? 1 : 0);
  endtask

  task automatic cycle(input logic c, input logic l, input logic r, input logic [15:0] w,
                       input string tag);
    clr = c; lap = l; recall = r;
    {d3, d2, d1, d0} = w;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; lap = 1'b0; recall = 1'b0;
    {d3, d2, d1, d0} = 16'h0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Live path and ignored recall while empty
    cycle(0, 0, 0, 16'h0123, "live_delay");
    cycle(0, 0, 1, 16'h0123, "recall_empty");

    // Three laps, then browse newest to oldest and wrap back to live
    cycle(0, 1, 0, 16'h0012, "lap1");
    cycle(0, 1, 0, 16'h0034, "lap2");
    cycle(0, 1, 0, 16'h0056, "lap3");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 16'h9999, "browse3");
    cycle(0, 0, 0, 16'h4321, "browse3_idle");

    // Lap and recall together while browsing
    cycle(0, 0, 1, 16'h1111, "enter_browse");
    cycle(0, 1, 1, 16'h0777, "lap_recall");
    cycle(0, 0, 0, 16'h0888, "lap_recall_idle");

    // Clear while browsing with five laps stored
    cycle(0, 1, 0, 16'h0555, "lap5");
    cycle(0, 0, 1, 16'h0000, "browse5");
    cycle(0, 0, 1, 16'h0000, "browse5b");
    cycle(1, 0, 0, 16'h2222, "clr_browse");

    // Overflow: ten laps into an eight-deep ring, then walk the whole history
    for (int i = 1; i <= 10; i++) cycle(0, 1, 0, bcd(i), "overflow_lap");
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 16'h5555, "overflow_browse");
    cycle(0, 0, 0, 16'h6666, "overflow_idle");

    // Asynchronous reset between edges while browsing; a lap held during reset is lost
    cycle(0, 0, 1, 16'h0000, "pre_rst_browse");
    cycle(0, 0, 1, 16'h0000, "pre_rst_browse2");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    lap = 1'b1;
    {d3, d2, d1, d0} = 16'h0999;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lap = 1'b0;
    rst = 1'b1;
    #1;
    check_all("rst_release");
    cycle(0, 0, 1, 16'h0321, "rst_pulse_lost");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
            bcd($urandom_range(0, 9999)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
